parity_stream_gen_chk: RTL and testbench

//  Pipelined multi-lane parity generator/checker with a valid/ready stream interface.
//  Per lane: generates even or odd parity over LANE_W bits and checks a received parity bit.

---
 rtl/parity_pkg.sv | 7 +
 rtl/parity_lane.sv | 13 +
 rtl/parity_stream_gen_chk.sv | 111 +++++++++++
 tb/tb_parity_stream_gen_chk.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared parity constants and default lane geometry
package parity_pkg;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_LANES  = 4;
endpackage

// File: rtl/parity_lane.sv
// rtl/parity_lane.sv - combinational parity generate/check for one lane
module parity_lane #(
    parameter int LANE_W = parity_pkg::DEF_LANE_W
) (
    input  logic [LANE_W-1:0] lane_data,
    input  logic              par,
    input  logic              odd,
    output logic              gen,
    output logic              err
);
    assign gen = (^lane_data) ^ odd;
    assign err = par ^ gen;
endmodule

// File: rtl/parity_stream_gen_chk.sv
// rtl/parity_stream_gen_chk.sv - one-stage multi-lane parity gen/check with valid/ready handshake
// Define PARITY_ERR_CNT_EN to build the saturating errored-beat counter; otherwise err_count is 0.
module parity_stream_gen_chk
    import parity_pkg::*;
#(
    parameter int LANE_W    = DEF_LANE_W,
    parameter int LANES     = DEF_LANES,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [LANES-1:0]        in_par,
    input  logic                    in_odd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_par,
    output logic [LANES-1:0]        out_err,
    input  logic                    clr_err,
    output logic                    sticky_err,
    output logic [ERR_CNT_W-1:0]    err_count
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LANES*LANE_W-1:0] r_data;
    logic [LANES-1:0]        r_par;
    logic [LANES-1:0]        r_err;
    logic                    r_sticky;
    logic [LANES-1:0]        w_gen;
    logic [LANES-1:0]        w_err;
    logic                    w_accept;
    logic                    w_err_beat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane #(.LANE_W(LANE_W)) u_lane (
            .lane_data (in_data[i*LANE_W +: LANE_W]),
            .par       (in_par[i]),
            .odd       (in_odd),
            .gen       (w_gen[i]),
            .err       (w_err[i])
        );
    end

    assign out_valid  = (r_state == FULL);
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_err_beat = w_accept && (|w_err);

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = FULL;
            FULL:  if (!w_accept && out_ready) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Payload loads only on accept, so it is naturally stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_par  <= '0;
            r_err  <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_par  <= w_gen;
            r_err  <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             r_sticky <= 1'b0;
        else if (w_err_beat) r_sticky <= 1'b1;
        else if (clr_err)    r_sticky <= 1'b0;
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_cnt;

    // An errored beat coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_err_beat) begin
            if (clr_err)         r_cnt <= ERR_CNT_W'(1);
            else if (r_cnt != '1) r_cnt <= r_cnt + ERR_CNT_W'(1);
        end else if (clr_err) begin
            r_cnt <= '0;
        end
    end

    assign err_count = r_cnt;
`else
    assign err_count = '0;
`endif

    assign out_data   = r_data;
    assign out_par    = r_par;
    assign out_err    = r_err;
    assign sticky_err = r_sticky;
endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// tb/tb_parity_stream_gen_chk.sv - self-checking bench for parity_stream_gen_chk
module tb_parity_stream_gen_chk;
    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_par = '0;
    logic        in_odd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_par;
    logic [3:0]  out_err;
    logic        clr_err = 1'b0;
    logic        sticky_err;
    logic [CW-1:0] err_count;

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 0;

    parity_stream_gen_chk #(.LANE_W(8), .LANES(4), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_par(in_par), .in_odd(in_odd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_par(out_par), .out_err(out_err),
        .clr_err(clr_err), .sticky_err(sticky_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_par(input logic [31:0] d, input logic odd);
        logic [3:0] g;
        for (int i = 0; i < 4; i++) g[i] = (($countones(d[i*8 +: 8]) % 2) == 1) ^ odd;
        return g;
    endfunction

    // Reference model: behaviour of a one-deep output buffer and the error bookkeeping.
    logic        m_valid = 0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_par = '0;
    logic [3:0]  m_err = '0;
    logic        m_sticky = 0;
    int          m_cnt = 0;
    wire         m_ready = !m_valid || out_ready;

    always @(posedge clk) begin
        logic [3:0] g;
        bit acc;
        bit errb;
        g = exp_par(in_data, in_odd);
        acc = in_valid && m_ready;
        errb = acc && ((in_par ^ g) != 4'b0);
        if (rst) begin
            m_valid <= 0; m_data <= '0; m_par <= '0; m_err <= '0;
            m_sticky <= 0; m_cnt <= 0;
        end else begin
            if (acc) begin
                m_valid <= 1; m_data <= in_data; m_par <= g; m_err <= in_par ^ g;
            end else if (out_ready) begin
                m_valid <= 0;
            end
            if (errb) m_sticky <= 1;
            else if (clr_err) m_sticky <= 0;
`ifdef PARITY_ERR_CNT_EN
            if (errb) m_cnt <= clr_err ? 1 : ((m_cnt < (2**CW) - 1) ? m_cnt + 1 : m_cnt);
            else if (clr_err) m_cnt <= 0;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_data", out_data, m_data);
            check("out_par", 32'(out_par), 32'(m_par));
            check("out_err", 32'(out_err), 32'(m_err));
            check("sticky_err", 32'(sticky_err), 32'(m_sticky));
            check("err_count", 32'(err_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] p, input logic odd);
        in_valid = 1; in_data = d; in_par = p; in_odd = odd;
        step();
        in_valid = 0; clr_err = 0;
    endtask

    int exp_sat;
    int exp_one;

    initial begin
`ifdef PARITY_ERR_CNT_EN
        exp_sat = 3; exp_one = 1;
`else
        exp_sat = 0; exp_one = 0;
`endif
        step();
        started = 1;
        step();
        check("rst out_valid", 32'(out_valid), 0);
        check("rst err_count", 32'(err_count), 0);
        rst = 0;
        step();

        // generation, even then odd
        beat(32'h000103FF, 4'b0100, 1'b0);
        check("even out_par", 32'(out_par), 32'b0100);
        check("even out_err", 32'(out_err), 0);
        check("even sticky", 32'(sticky_err), 0);
        beat(32'h000103FF, 4'b1011, 1'b1);
        check("odd out_par", 32'(out_par), 32'b1011);
        step();

        // single-lane error
        beat(32'h000103FF, 4'b0101, 1'b0);
        check("chk out_err", 32'(out_err), 32'b0001);
        check("chk sticky", 32'(sticky_err), 1);
        check("chk count", 32'(err_count), 32'(exp_one));
        step();

        // backpressure: FULL with out_ready low, a second beat waits
        out_ready = 0;
        beat(32'hA5A5_0F0F, 4'b1111, 1'b0);
        in_valid = 1; in_data = 32'h1234_5678; in_par = 4'b0000; in_odd = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", 32'(in_ready), 0);
            check("bp out_data", out_data, 32'hA5A5_0F0F);
            step();
        end
        out_ready = 1;
        step();
        check("bp released data", out_data, 32'h1234_5678);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = $urandom; in_par = 4'($urandom); in_odd = 1'($urandom);
            step();
            check("burst out_valid", 32'(out_valid), 1);
        end
        in_valid = 0;
        step();

        // saturation and simultaneous clear
        clr_err = 1;
        step();
        clr_err = 0;
        check("clr sticky", 32'(sticky_err), 0);
        check("clr count", 32'(err_count), 0);
        for (int i = 0; i < 5; i++) beat(32'h0000_00FF, 4'b0001, 1'b0);
        check("sat count", 32'(err_count), 32'(exp_sat));
        check("sat sticky", 32'(sticky_err), 1);
        clr_err = 1;
        beat(32'h0000_00FF, 4'b0001, 1'b0);
        check("clr+err count", 32'(err_count), 32'(exp_one));
        check("clr+err sticky", 32'(sticky_err), 1);

        // reset while FULL under backpressure
        out_ready = 0;
        beat(32'hDEAD_BEEF, 4'b0000, 1'b0);
        check("pre-rst out_valid", 32'(out_valid), 1);
        rst = 1; in_valid = 1;
        step();
        rst = 0; in_valid = 0;
        check("post-rst out_valid", 32'(out_valid), 0);
        check("post-rst sticky", 32'(sticky_err), 0);
        check("post-rst count", 32'(err_count), 0);
        check("post-rst in_ready", 32'(in_ready), 1);
        out_ready = 1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
